pc_sequencer: RTL and testbench

//  Next-PC controller that drives the program counter of the single-cycle MIPS core.
//  - Picks the next fetch address: sequential, branch, jump or register jump.
//  - Runs a post-reset boot hold, stall hold and halt/resume FSM.
//  - Owns the PC register itself; the fetch stage reads pc/pc_valid.

---
 rtl/pc_seq_pkg.sv | 14 +
 rtl/pc_seq_if.sv | 44 ++++
 rtl/pc_target_mux.sv | 72 +++++++
 rtl/pc_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int WORD_SHIFT = 2;
    localparam int JT_WIDTH   = 26;
    localparam int IMM_WIDTH  = 16;

endpackage

// File: rtl/pc_seq_if.sv
// Request/response bundle between the core and the next-PC sequencer.
// With PC_SEQ_EXCEPTION_EN defined, carries exc_req and epc as well.
interface pc_seq_if
    import pc_seq_pkg::*;
#(
    parameter int SIZE = 32
) ();

    logic                  stall;
    logic                  branch_taken;
    logic [IMM_WIDTH-1:0]  imm;
    logic                  jump;
    logic [JT_WIDTH-1:0]   jtarget;
    logic                  jr;
    logic [SIZE-1:0]       rs_val;
    logic                  halt;
    logic                  resume;
`ifdef PC_SEQ_EXCEPTION_EN
    logic                  exc_req;
    logic [SIZE-1:0]       epc;
`endif
    logic [SIZE-1:0]       pc;
    logic [SIZE-1:0]       pc_plus4;
    logic                  pc_valid;
    logic                  align_err;
    state_t                state;

    modport master (
        output stall, branch_taken, imm, jump, jtarget, jr, rs_val, halt, resume,
`ifdef PC_SEQ_EXCEPTION_EN
        output exc_req, input epc,
`endif
        input  pc, pc_plus4, pc_valid, align_err, state
    );

    modport slave (
        input  stall, branch_taken, imm, jump, jtarget, jr, rs_val, halt, resume,
`ifdef PC_SEQ_EXCEPTION_EN
        input  exc_req, output epc,
`endif
        output pc, pc_plus4, pc_valid, align_err, state
    );

endinterface

// File: rtl/pc_target_mux.sv
// Combinational next-PC target generation and RUN-state priority select.
// With PC_SEQ_EXCEPTION_EN defined, an exception request outranks everything.
module pc_target_mux
    import pc_seq_pkg::*;
#(
    parameter int SIZE = 32
`ifdef PC_SEQ_EXCEPTION_EN
   ,parameter logic [SIZE-1:0] EXC_VEC = SIZE'('h80)
`endif
) (
    input  logic [SIZE-1:0]      pc,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic                 jump,
    input  logic [JT_WIDTH-1:0]  jtarget,
    input  logic                 jr,
    input  logic [SIZE-1:0]      rs_val,
    input  logic                 halt,
`ifdef PC_SEQ_EXCEPTION_EN
    input  logic                 exc_req,
    output logic                 take_exc,
`endif
    output logic [SIZE-1:0]      pc_plus4,
    output logic [SIZE-1:0]      next_pc,
    output logic                 take_halt,
    output logic                 misaligned
);

    // Low bits replaced by a J-type target; the rest come from pc+4 (region bits).
    localparam logic [SIZE-1:0] JT_MASK = SIZE'({(JT_WIDTH + WORD_SHIFT){1'b1}});

    logic [SIZE-1:0] br_off;
    logic [SIZE-1:0] br_tgt;
    logic [SIZE-1:0] j_tgt;
    logic [SIZE-1:0] jr_tgt;

    assign pc_plus4 = pc + SIZE'(4);
    assign br_off   = {{(SIZE - IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm} << WORD_SHIFT;
    assign br_tgt   = pc_plus4 + br_off;
    assign j_tgt    = (pc_plus4 & ~JT_MASK) | SIZE'({jtarget, {WORD_SHIFT{1'b0}}});
    assign jr_tgt   = {rs_val[SIZE-1:WORD_SHIFT], {WORD_SHIFT{1'b0}}};

    // Priority select: only the winning request affects the target or the error flag.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        next_pc    = pc_plus4;
        take_halt  = 1'b0;
        misaligned = 1'b0;
`ifdef PC_SEQ_EXCEPTION_EN
        take_exc   = 1'b0;
        if (exc_req) begin
            take_exc = 1'b1;
            next_pc  = EXC_VEC;
        end else
`endif
        if (halt) begin
            take_halt = 1'b1;
            next_pc   = pc_plus4;
        end else if (stall) begin
            next_pc = pc;
        end else if (jr) begin
            next_pc    = jr_tgt;
            misaligned = |rs_val[WORD_SHIFT-1:0];
        end else if (jump) begin
            next_pc = j_tgt;
        end else if (branch_taken) begin
            next_pc = br_tgt;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: boot hold, run and halt FSM plus the PC register itself.
// Optional build macro PC_SEQ_EXCEPTION_EN adds exc_req/epc and exception redirect.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              SIZE        = 32,
    parameter logic [SIZE-1:0] RESET_VEC   = '0,
    parameter int              BOOT_CYCLES = 2
`ifdef PC_SEQ_EXCEPTION_EN
   ,parameter logic [SIZE-1:0] EXC_VEC     = SIZE'('h80)
`endif
) (
    input  logic     clk,
    input  logic     reset,
    pc_seq_if.slave  bus
);

    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]  pc_q, pc_d;
    logic             align_q, align_d;
    logic [SIZE-1:0]  next_pc;
    logic             take_halt;
    logic             misaligned;
`ifdef PC_SEQ_EXCEPTION_EN
    logic [SIZE-1:0]  epc_q, epc_d;
    logic             take_exc;
`endif

    pc_target_mux #(
        .SIZE(SIZE)
`ifdef PC_SEQ_EXCEPTION_EN
       ,.EXC_VEC(EXC_VEC)
`endif
    ) u_mux (
        .pc          (pc_q),
        .stall       (bus.stall),
        .branch_taken(bus.branch_taken),
        .imm         (bus.imm),
        .jump        (bus.jump),
        .jtarget     (bus.jtarget),
        .jr          (bus.jr),
        .rs_val      (bus.rs_val),
        .halt        (bus.halt),
`ifdef PC_SEQ_EXCEPTION_EN
        .exc_req     (bus.exc_req),
        .take_exc    (take_exc),
`endif
        .pc_plus4    (bus.pc_plus4),
        .next_pc     (next_pc),
        .take_halt   (take_halt),
        .misaligned  (misaligned)
    );

    // State, counter and PC registers; reset returns to BOOT at once.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= BOOT;
            cnt_q   <= '0;
            pc_q    <= RESET_VEC;
            align_q <= 1'b0;
`ifdef PC_SEQ_EXCEPTION_EN
            epc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            align_q <= align_d;
`ifdef PC_SEQ_EXCEPTION_EN
            epc_q   <= epc_d;
`endif
        end
    end

    // Next-state logic; align_err defaults low so it only pulses for one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        align_d = 1'b0;
`ifdef PC_SEQ_EXCEPTION_EN
        epc_d   = epc_q;
`endif
        unique case (state_q)
            BOOT: begin
                if (cnt_q == CNT_W'(BOOT_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                pc_d    = next_pc;
                align_d = misaligned;
`ifdef PC_SEQ_EXCEPTION_EN
                if (take_exc) epc_d = pc_q;
`endif
                if (take_halt) state_d = HALT;
            end
            HALT: begin
`ifdef PC_SEQ_EXCEPTION_EN
                if (bus.exc_req) begin
                    epc_d   = pc_q;
                    pc_d    = next_pc;
                    state_d = RUN;
                end else
`endif
                if (bus.resume) state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = (state_q == RUN);
    assign bus.align_err = align_q;
    assign bus.state     = state_q;
`ifdef PC_SEQ_EXCEPTION_EN
    assign bus.epc       = epc_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed cases plus randomized requests
// compared every cycle against a behavioural model. Honours PC_SEQ_EXCEPTION_EN.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int          SIZE        = 32;
    localparam int          BOOT_CYCLES = 2;
    localparam logic [31:0] EXC_VEC     = 32'h80;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    pc_seq_if #(.SIZE(SIZE)) bus ();

    pc_sequencer #(
        .SIZE       (SIZE),
        .RESET_VEC  (32'h0),
        .BOOT_CYCLES(BOOT_CYCLES)
`ifdef PC_SEQ_EXCEPTION_EN
       ,.EXC_VEC    (EXC_VEC)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [31:0] m_pc;
    bit [31:0] m_epc;
    int        m_boot_left;
    bit        m_halted;
    bit        m_align;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc        = 32'h0;
        m_epc       = 32'h0;
        m_boot_left = BOOT_CYCLES;
        m_halted    = 1'b0;
        m_align     = 1'b0;
    endtask

    // One clock edge of the architectural behaviour.
    task automatic model_edge();
        m_align = 1'b0;
        if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (m_halted) begin
`ifdef PC_SEQ_EXCEPTION_EN
            if (bus.exc_req) begin
                m_epc    = m_pc;
                m_pc     = EXC_VEC;
                m_halted = 1'b0;
            end else
`endif
            if (bus.resume) m_halted = 1'b0;
        end else begin
`ifdef PC_SEQ_EXCEPTION_EN
            if (bus.exc_req) begin
                m_epc = m_pc;
                m_pc  = EXC_VEC;
            end else
`endif
            if (bus.halt) begin
                m_pc     = m_pc + 4;
                m_halted = 1'b1;
            end else if (bus.stall) begin
                m_pc = m_pc;
            end else if (bus.jr) begin
                m_align = (bus.rs_val % 4) != 0;
                m_pc    = (bus.rs_val / 4) * 4;
            end else if (bus.jump) begin
                m_pc = ((m_pc + 4) & 32'hF000_0000) + 32'(bus.jtarget) * 4;
            end else if (bus.branch_taken) begin
                m_pc = m_pc + 4 + 32'(int'($signed(bus.imm)) * 4);
            end else begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic check_all(input string tag);
        state_t exp_state;
        exp_state = (m_boot_left > 0) ? BOOT : (m_halted ? HALT : RUN);
        check({tag, ".state"},     bus.state,     exp_state);
        check({tag, ".pc"},        bus.pc,        m_pc);
        check({tag, ".pc_plus4"},  bus.pc_plus4,  32'(m_pc + 4));
        check({tag, ".pc_valid"},  bus.pc_valid,  exp_state == RUN);
        check({tag, ".align_err"}, bus.align_err, m_align);
`ifdef PC_SEQ_EXCEPTION_EN
        check({tag, ".epc"},       bus.epc,       m_epc);
`endif
    endtask

    task automatic clear_inputs();
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.imm          = '0;
        bus.jump         = 1'b0;
        bus.jtarget      = '0;
        bus.jr           = 1'b0;
        bus.rs_val       = '0;
        bus.halt         = 1'b0;
        bus.resume       = 1'b0;
`ifdef PC_SEQ_EXCEPTION_EN
        bus.exc_req      = 1'b0;
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_pc(input logic [31:0] addr);
        clear_inputs();
        bus.jr     = 1'b1;
        bus.rs_val = addr;
        tick("set_pc");
        clear_inputs();
    endtask

    task automatic drive_random();
        clear_inputs();
        bus.stall        = ($urandom_range(3) == 0);
        bus.branch_taken = ($urandom_range(3) == 0);
        bus.jump         = ($urandom_range(7) == 0);
        bus.jr           = ($urandom_range(7) == 0);
        bus.halt         = ($urandom_range(15) == 0);
        bus.resume       = ($urandom_range(3) == 0);
        bus.imm          = 16'($urandom);
        bus.jtarget      = 26'($urandom);
        bus.rs_val       = $urandom;
        if ($urandom_range(1) == 0) bus.rs_val[1:0] = 2'b00;
`ifdef PC_SEQ_EXCEPTION_EN
        bus.exc_req      = ($urandom_range(31) == 0);
`endif
    endtask

    initial begin
        logic [31:0] held_pc;
        clear_inputs();

        // Power-on reset and boot hold
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        #1 check_all("boot0");
        check("boot0.valid_lit", bus.pc_valid, 1'b0);
        tick("boot1");
        check("boot1.valid_lit", bus.pc_valid, 1'b0);
        tick("run0");
        check("run0.pc_lit", bus.pc, 32'h0);
        check("run0.valid_lit", bus.pc_valid, 1'b1);
        tick("run1");
        check("run1.pc_lit", bus.pc, 32'h4);
        tick("run2");
        check("run2.pc_lit", bus.pc, 32'h8);

        // Branch backward and maximum forward offset
        set_pc(32'h100);
        bus.branch_taken = 1'b1;
        bus.imm          = 16'hFFFE;
        tick("br_neg");
        check("br_neg.pc_lit", bus.pc, 32'hFC);
        set_pc(32'h100);
        bus.branch_taken = 1'b1;
        bus.imm          = 16'h7FFF;
        tick("br_max");
        check("br_max.pc_lit", bus.pc, 32'h0002_0100);

        // Jump keeps the region bits of pc+4
        set_pc(32'h1000_0000);
        bus.jump    = 1'b1;
        bus.jtarget = 26'h40;
        tick("jump");
        check("jump.pc_lit", bus.pc, 32'h1000_0100);

        // Misaligned register jump: flag pulses for exactly one cycle
        clear_inputs();
        bus.jr     = 1'b1;
        bus.rs_val = 32'h203;
        tick("jr_mis");
        check("jr_mis.pc_lit", bus.pc, 32'h200);
        check("jr_mis.err_lit", bus.align_err, 1'b1);
        clear_inputs();
        tick("jr_mis_clr");
        check("jr_mis_clr.err_lit", bus.align_err, 1'b0);

        // jr + jump + branch together: jr wins
        bus.jr           = 1'b1;
        bus.rs_val       = 32'h300;
        bus.jump         = 1'b1;
        bus.jtarget      = 26'h55;
        bus.branch_taken = 1'b1;
        bus.imm          = 16'h5;
        tick("jr_prio");
        check("jr_prio.pc_lit", bus.pc, 32'h300);

        // Stall for 3 clocks
        clear_inputs();
        held_pc   = bus.pc;
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            check("stall.pc_lit", bus.pc, held_pc);
        end

        // Halt (with stall: halt wins), inputs ignored while halted, resume
        set_pc(32'h40);
        bus.halt  = 1'b1;
        bus.stall = 1'b1;
        tick("halt");
        check("halt.pc_lit", bus.pc, 32'h44);
        check("halt.state_lit", bus.state, HALT);
        check("halt.valid_lit", bus.pc_valid, 1'b0);
        clear_inputs();
        bus.jr     = 1'b1;
        bus.rs_val = 32'h999;
        bus.jump   = 1'b1;
        tick("halt_ignore");
        check("halt_ignore.pc_lit", bus.pc, 32'h44);
        clear_inputs();
        bus.resume = 1'b1;
        tick("resume");
        check("resume.state_lit", bus.state, RUN);
        clear_inputs();
        tick("resume_next");
        check("resume_next.pc_lit", bus.pc, 32'h48);

        // Sequential wrap and branch overflow wrap
        set_pc(32'hFFFF_FFFC);
        tick("wrap");
        check("wrap.pc_lit", bus.pc, 32'h0);
        set_pc(32'hFFFF_FFF0);
        bus.branch_taken = 1'b1;
        bus.imm          = 16'h10;
        tick("br_wrap");
        check("br_wrap.pc_lit", bus.pc, 32'h34);

`ifdef PC_SEQ_EXCEPTION_EN
        // Exception redirect in RUN, over halt, and out of HALT
        set_pc(32'h20);
        bus.exc_req = 1'b1;
        tick("exc");
        check("exc.epc_lit", bus.epc, 32'h20);
        check("exc.pc_lit", bus.pc, 32'h80);
        set_pc(32'h60);
        bus.exc_req = 1'b1;
        bus.halt    = 1'b1;
        tick("exc_halt");
        check("exc_halt.state_lit", bus.state, RUN);
        check("exc_halt.pc_lit", bus.pc, 32'h80);
        set_pc(32'h70);
        bus.halt = 1'b1;
        tick("halt_for_exc");
        clear_inputs();
        bus.exc_req = 1'b1;
        tick("exc_from_halt");
        check("exc_from_halt.epc_lit", bus.epc, 32'h74);
        check("exc_from_halt.state_lit", bus.state, RUN);
        clear_inputs();
`endif

        // Randomized requests against the model
        for (int i = 0; i < 400; i++) begin
            drive_random();
            tick("rand");
        end

        // Reset while halted returns to BOOT immediately
        clear_inputs();
        bus.resume = 1'b1;
        tick("rand_exit");
        set_pc(32'h500);
        bus.halt = 1'b1;
        tick("pre_reset_halt");
        clear_inputs();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("halt_reset.pc_lit", bus.pc, 32'h0);
        check("halt_reset.state_lit", bus.state, BOOT);
        check_all("halt_reset");
        @(negedge clk);
        reset = 1'b0;
        tick("reboot1");
        tick("reboot2");
        tick("reboot3");
        check("reboot3.pc_lit", bus.pc, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
